// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial divider datapath.
//   ALU_W        : default operand width shared by ALU_top and its feeders
//   ser_state_e  : operand serializer FSM states
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/piso_shreg.sv
// W-bit parallel-in serial-out shift register, MSB first.
//   clk, rst_n : clock, async active-low reset (clears the register)
//   load       : capture din (wins over shift_en)
//   shift_en   : shift left one place, zero fill
//   din        : parallel load word
//   msb        : current serial bit (register bit W-1)
module piso_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sh <= '0;
    else if (load)     sh <= din;
    else if (shift_en) sh <= {sh[W-2:0], 1'b0};
  end

  assign msb = sh[W-1];

endmodule

// File: rtl/alu_operand_serializer.sv
// Feeds one dividend/divisor pair to the bit-serial divider, MSB first,
// over a tvalid/tready bit handshake. Optionally drops zero divisors.
//   clk, res          : clock, async active-low reset
//   in_valid/in_ready : parallel operand handshake (in_a dividend, in_b divisor)
//   A, B              : serial dividend / divisor bits
//   tvalid/tready     : per-bit handshake with the divider
//   tlast             : current bit is bit 0 of the frame
//   err_zero          : one-cycle pulse after a zero-divisor pair is dropped
// Note: in_ready depends combinationally on tready so a new pair can be
// taken on the last-bit edge and frames run back to back with no bubble.
module alu_operand_serializer
  import alu_pkg::*;
#(
  parameter int W          = ALU_W,
  parameter bit CHECK_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         res,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         A,
  output logic         B,
  output logic         tvalid,
  input  logic         tready,
  output logic         tlast,
  output logic         err_zero
);

  localparam int             CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  ser_state_e    state;
  logic [CW-1:0] cnt;
  logic          msb_a, msb_b;
  logic          xfer, last_xfer, accept, reject, load;

  assign tvalid    = (state == SHIFT);
  assign tlast     = tvalid && (cnt == LAST);
  assign xfer      = tvalid && tready;
  assign last_xfer = tlast && tready;
  assign in_ready  = (state == IDLE) || last_xfer;
  assign accept    = in_valid && in_ready;
  assign reject    = accept && CHECK_ZERO && (in_b == '0);
  assign load      = accept && !reject;

  // Gate with state so the serial lines read 0 whenever no bit is offered.
  assign A = tvalid & msb_a;
  assign B = tvalid & msb_b;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      cnt      <= '0;
      err_zero <= 1'b0;
    end else begin
      err_zero <= reject;
      if (load) begin
        state <= SHIFT;
        cnt   <= '0;
      end else begin
        if (last_xfer) state <= IDLE;
        if (xfer)      cnt   <= cnt + 1'b1;
      end
    end
  end

  // A load on the last-bit edge overrides that edge's shift.
  piso_shreg #(.W(W)) u_sh_a (
    .clk      (clk),
    .rst_n    (res),
    .load     (load),
    .shift_en (xfer),
    .din      (in_a),
    .msb      (msb_a)
  );

  piso_shreg #(.W(W)) u_sh_b (
    .clk      (clk),
    .rst_n    (res),
    .load     (load),
    .shift_en (xfer),
    .din      (in_b),
    .msb      (msb_b)
  );

endmodule

// File: tb/tb_alu_operand_serializer.sv
module tb_alu_operand_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         tready = 1'b1;

  // dut: CHECK_ZERO=1
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, A, B, tvalid, tlast, err_zero;

  // dut0: CHECK_ZERO=0, separate operand inputs
  logic         in_valid0 = 1'b0;
  logic [W-1:0] in_a0 = '0, in_b0 = '0;
  logic         in_ready0, A0, B0, tvalid0, tlast0, err_zero0;

  int total = 0;
  int bad   = 0;
  int cycles;

  always #5 clk = ~clk;

  alu_operand_serializer #(.W(W), .CHECK_ZERO(1'b1)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .A(A), .B(B), .tvalid(tvalid),
    .tready(tready), .tlast(tlast), .err_zero(err_zero)
  );

  alu_operand_serializer #(.W(W), .CHECK_ZERO(1'b0)) dut0 (
    .clk(clk), .res(res), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .A(A0), .B(B0), .tvalid(tvalid0),
    .tready(tready), .tlast(tlast0), .err_zero(err_zero0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a pair on dut, then check all W bits with tready=1 and the drop after.
  task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; tready = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("%s_v%0d", tag, i), tvalid, 1);
      chk($sformatf("%s_a%0d", tag, i), A, a[W-1-i]);
      chk($sformatf("%s_b%0d", tag, i), B, b[W-1-i]);
      chk($sformatf("%s_l%0d", tag, i), tlast, (i == W-1));
    end
    @(negedge clk);
    chk({tag, "_end"}, tvalid, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;

    // Reset state
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_err", err_zero, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_rdy0", in_ready0, 1);
    repeat (2) @(negedge clk);
    res = 1'b1;

    // Single frame
    send("single", 16'h5D91, 16'h0003);

    // Backpressure: two stall cycles on bits 3 and 9
    a = 16'h5D91; b = 16'h0003; cycles = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; tready = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == 3 || i == 9) begin
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          in_valid = 1'b0; tready = 1'b0;
          cycles += int'(tvalid);
          chk($sformatf("bp_sa%0d_%0d", i, s), A, a[W-1-i]);
          chk($sformatf("bp_sb%0d_%0d", i, s), B, b[W-1-i]);
          chk($sformatf("bp_sl%0d_%0d", i, s), tlast, 0);
          chk($sformatf("bp_sr%0d_%0d", i, s), in_ready, 0);
        end
      end
      @(negedge clk);
      in_valid = 1'b0; tready = 1'b1;
      cycles += int'(tvalid);
      chk($sformatf("bp_a%0d", i), A, a[W-1-i]);
      chk($sformatf("bp_b%0d", i), B, b[W-1-i]);
      chk($sformatf("bp_l%0d", i), tlast, (i == W-1));
    end
    chk("bp_cycles", cycles, 20);
    @(negedge clk);
    chk("bp_end", tvalid, 0);

    // Back-to-back frames with in_valid held
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001;
    cycles = 0;
    for (int i = 0; i < 2*W; i++) begin
      @(negedge clk);
      if (i == 0) begin in_a = 16'h8000; in_b = 16'h0002; end
      if (i == 2*W-1) in_valid = 1'b0;
      a = (i < W) ? 16'hFFFF : 16'h8000;
      b = (i < W) ? 16'h0001 : 16'h0002;
      cycles += int'(tvalid);
      chk($sformatf("b2b_a%0d", i), A, a[W-1-(i%W)]);
      chk($sformatf("b2b_b%0d", i), B, b[W-1-(i%W)]);
      chk($sformatf("b2b_l%0d", i), tlast, ((i%W) == W-1));
      chk($sformatf("b2b_r%0d", i), in_ready, ((i%W) == W-1));
    end
    chk("b2b_cycles", cycles, 32);
    @(negedge clk);
    chk("b2b_end", tvalid, 0);

    // Zero divisor rejected
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("z1_err", err_zero, 1);
    chk("z1_tv", tvalid, 0);
    chk("z1_rdy", in_ready, 1);
    @(negedge clk);
    chk("z1_err_off", err_zero, 0);
    chk("z1_tv2", tvalid, 0);
    send("z1_next", 16'hC001, 16'h8001);

    // Zero divisor passed through when checking is off
    a = 16'h5D91;
    @(negedge clk);
    in_valid0 = 1'b1; in_a0 = a; in_b0 = 16'h0000;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      in_valid0 = 1'b0;
      chk($sformatf("z0_v%0d", i), tvalid0, 1);
      chk($sformatf("z0_a%0d", i), A0, a[W-1-i]);
      chk($sformatf("z0_b%0d", i), B0, 0);
      chk($sformatf("z0_e%0d", i), err_zero0, 0);
      chk($sformatf("z0_l%0d", i), tlast0, (i == W-1));
    end
    @(negedge clk);
    chk("z0_end", tvalid0, 0);
    chk("z0_err_end", err_zero0, 0);

    // Mid-frame asynchronous reset
    a = 16'h5D91; b = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    // bits 0..7 transferred, bit 8 now offered
    chk("mr_pre_v", tvalid, 1);
    chk("mr_pre_a", A, a[W-1-8]);
    chk("mr_pre_b", B, 1);
    #2 res = 1'b0;
    #1;
    chk("mr_v", tvalid, 0);
    chk("mr_a", A, 0);
    chk("mr_b", B, 0);
    chk("mr_l", tlast, 0);
    chk("mr_rdy", in_ready, 1);
    @(negedge clk);
    res = 1'b1;
    chk("mr_rel_v", tvalid, 0);
    chk("mr_rel_rdy", in_ready, 1);
    send("mr_new", 16'hA6C3, 16'h4001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_serializer.md
# alu_operand_serializer

Upstream feeder for the bit-serial divider `ALU_top`. Accepts one dividend/divisor pair as parallel words over a valid/ready handshake. Shifts both words out MSB-first on the `A`/`B` serial lines under the divider's `tvalid`/`tready` handshake. Optionally rejects a zero divisor before it reaches the divider.

## Interface
- `W`, 16: operand width in bits; must be ≥ 2.
- `CHECK_ZERO`, 1: if 1, a pair with `in_b == 0` is dropped and flagged; if 0, it is serialized normally.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `res`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: serializer can accept a pair this cycle.
- `in_a`  in  W: dividend.
- `in_b`  in  W: divisor.
- `A`  out  1: current dividend bit to the divider.
- `B`  out  1: current divisor bit to the divider.
- `tvalid`  out  1: `A`/`B` hold a valid bit.
- `tready`  in  1: divider accepts the current bit.
- `tlast`  out  1: the current bit is bit 0, the last of the frame.
- `err_zero`  out  1: one-cycle pulse when a pair is dropped for a zero divisor.

## Operation
- States:
  - IDLE: `tvalid=0`, `in_ready=1`.
  - SHIFT: `tvalid=1`.
- Acceptance happens when `in_valid && in_ready` at an edge.
  - If `CHECK_ZERO=1` and `in_b==0`: stay in IDLE, pulse `err_zero` for the next cycle, send nothing.
  - Otherwise: load `in_a`/`in_b` into two W-bit shift registers, clear the bit counter `cnt` to 0, go to SHIFT.
- In SHIFT:
  - `A = sh_a[W-1]`, `B = sh_b[W-1]`.
  - A bit transfers at an edge where `tvalid && tready`.
  - On transfer, both registers shift left by one (zero fill) and `cnt` increments.
  - While `tready=0`, `A`, `B`, `tlast` and `cnt` hold stable.
- `tlast = (state==SHIFT) && (cnt==W-1)`.
- On the transfer of the last bit:
  - If a new pair is accepted at the same edge: reload and stay in SHIFT (back-to-back frames, no bubble).
  - Otherwise: return to IDLE.
- `in_ready = (state==IDLE) || (tlast && tready)`.
  - This is a combinational path from `tready` to `in_ready`; it is permitted and documented for integration.
- A zero-divisor pair accepted on a last-bit edge: the current frame completes, the FSM goes to IDLE, and `err_zero` pulses.
- `cnt` width is clog2(W). It never wraps within a frame; it is reloaded to 0 on every accept.

## Timing
- Reset (async assert, any state): `tvalid=0`, `tlast=0`, `A=0`, `B=0`, `err_zero=0`, `in_ready=1`, FSM=IDLE, `cnt=0`, shift registers 0.
  - Any frame in flight is abandoned; no partial bits resume after release.
- Reset release is synchronous to `clk`; the first accept can occur at the first rising edge after deassertion.
- Latency: pair accepted at edge N → `tvalid=1` with the MSBs on `A`/`B` during cycle N+1.
- Throughput: with `tready` held at 1, one frame every W cycles; back-to-back frames have no idle cycle.
- Frame duration is W bit-transfers; `tready` low stretches it by one cycle per low cycle.
- `err_zero` is high for exactly the one cycle after the rejecting edge.
- `in_a`/`in_b` are sampled only at the accept edge; later changes are ignored.

## Structure
- Shared package `alu_pkg`:
  - `ALU_W` default width (16), used by this block and `ALU_top`.
  - Serializer FSM state enum (IDLE, SHIFT).
- Sub-module `piso_shreg` (W-bit parallel-in serial-out register: load, shift-enable, MSB out), instantiated twice, once for A and once for B.
- The counter, FSM and handshake logic stay in the top of this block.

## Test plan
- Single frame, `tready=1`: `in_a=16'h5D91`, `in_b=16'h0003` → the `A` sequence is 0,1,0,1,1,1,0,1,1,0,0,1,0,0,0,1. The `B` sequence is 14×0 then 1,1. `tlast` is high only on the 16th bit. `tvalid` drops the cycle after.
- Backpressure: same pair, `tready` low on bits 3 and 9 for 2 cycles each → `A`/`B`/`tlast` stable while low. The bit sequence is unchanged and the frame lasts 20 cycles.
- Back-to-back: two pairs (`16'hFFFF`/`16'h0001`, then `16'h8000`/`16'h0002`) with `in_valid` held → `in_ready` pulses on the last-bit edge. 32 consecutive `tvalid` cycles, no gap.
- Zero divisor, `CHECK_ZERO=1`: `in_a=16'h1234`, `in_b=0` → `tvalid` stays 0 and `err_zero` is high for 1 cycle. A following valid pair is serialized normally.
- Zero divisor, `CHECK_ZERO=0`: `in_a=16'h5D91`, `in_b=0` → the full frame is sent with `B` all zeros and `err_zero` never asserts.
- Mid-frame reset: assert `res` low after bit 7 of a frame → `tvalid`, `A` and `B` go to 0 immediately, without waiting for a clock edge. After release, `in_ready=1`, and a new pair starts from its MSB.
